// File: rtl/mux_nway_reg.sv
// mux_nway_reg: registered N-input channel selector with valid/ready on every
// input and on the output. Explicit-select or round-robin grant, one output
// entry, one transfer per cycle (drain and load may happen on the same edge).
module mux_nway_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] chan_data [NUM_IN];
    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;
    int               rr_off;
    int               rr_best_off;

    // Unpack the flat input bus into per-channel words.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output slot can take a new entry when empty or being drained now.
    assign load_en = !out_valid || out_ready;

    // Grant selection. Round-robin picks the valid channel at the smallest
    // circular distance from ptr; an out-of-range sel simply matches nothing.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_off      = 0;
        rr_best_off = NUM_IN;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_valid[i]) begin
                    rr_off = (i >= int'(ptr_reg)) ? (i - int'(ptr_reg))
                                                  : (i + NUM_IN - int'(ptr_reg));
                    if (rr_off < rr_best_off) begin
                        rr_best_off = rr_off;
                        grant_valid = 1'b1;
                        grant_idx   = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Data of the granted channel, built as a mux so no index ever runs past NUM_IN.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = chan_data[i];
            end
        end
    end

    // Pointer advances to the channel after the winner, wrapping at NUM_IN.
    always_comb begin
        if (int'(grant_idx) == NUM_IN - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + SEL_W'(1);
        end
    end

    // One-hot ready; held low during reset so nothing is accepted then.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign in_ready[gi] = rst_n && load_en && grant_valid &&
                                  (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr_reg   <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nway_reg.sv
// Testbench for mux_nway_reg: directed scenarios plus random traffic checked
// against a transaction-level reference model; a 3-input instance covers the
// out-of-range select case.
module tb_mux_nway_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_valid3;

    logic [31:0]  d [4];

    // Reference model state (one output entry plus rotating pointer).
    bit           m_valid;
    logic [31:0]  m_data;
    int           m_sel;
    int           m_ptr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux_nway_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nway_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(1'b0), .sel(sel3), .out_data(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(1'b1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Which channel the rules grant right now, if any.
    function automatic void pick(output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < 4 && in_valid[sel]) begin
                ok = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!ok && in_valid[(m_ptr + k) % 4]) begin
                    ok = 1'b1;
                    g  = (m_ptr + k) % 4;
                end
            end
        end
    endfunction

    task automatic drive(input bit md, input int s, input logic [3:0] v, input bit rdy);
        mode      = md;
        sel       = 2'(s);
        in_valid  = v;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = d[i];
    endtask

    // One clock: check ready before the edge, advance model, check outputs after.
    task automatic cycle(input string tag);
        bit          ok;
        int          g;
        bit          load;
        logic [3:0]  exp_rdy;
        #1;
        pick(ok, g);
        load    = !m_valid || out_ready;
        exp_rdy = (load && ok) ? (4'b0001 << g) : 4'b0000;
        check({tag, ".in_ready"}, in_ready, exp_rdy);
        if (sel3 == 2'd3) check({tag, ".rdy3"}, in_ready3, 3'b000);
        @(posedge clk);
        if (load) begin
            if (ok) begin
                m_data  = d[g];
                m_sel   = g;
                m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, ".out_valid"}, out_valid, m_valid);
        check({tag, ".out_data"},  out_data,  m_data);
        check({tag, ".out_sel"},   out_sel,   m_sel);
        if (sel3 == 2'd3) check({tag, ".valid3"}, out_valid3, 1'b0);
        $display("%s: mode=%0d sel=%0d in_valid=%b out_ready=%0d -> out_valid=%0d out_sel=%0d out_data=%h",
                 tag, mode, sel, in_valid, out_ready, out_valid, out_sel, out_data);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 32'h10 + 32'(i);
        rst_n     = 1'b0;
        in_valid3 = 3'b111;
        in_data3  = {32'h22, 32'h21, 32'h20};
        sel3      = 2'd3;
        drive(1'b0, 2, 4'b1111, 1'b1);
        model_reset();
        #12;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_data",  out_data,  32'h0);
        check("rst.out_sel",   out_sel,   2'd0);
        check("rst.in_ready",  in_ready,  4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Explicit select, then a selected channel that is not valid.
        for (int n = 0; n < 4; n++) begin drive(1'b0, 2, 4'b1111, 1'b1); cycle("expl"); end
        drive(1'b0, 3, 4'b0111, 1'b1); cycle("expl_nov");

        // Round-robin, all valid then only channels 1 and 3.
        for (int n = 0; n < 8; n++) begin drive(1'b1, 0, 4'b1111, 1'b1); cycle("rr_all"); end
        for (int n = 0; n < 4; n++) begin drive(1'b1, 0, 4'b1010, 1'b1); cycle("rr_13"); end

        // Backpressure: take channel 2, stall three cycles, then drain+load ch3.
        drive(1'b1, 0, 4'b0100, 1'b1); cycle("bp_load");
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 0, 4'($urandom_range(1, 15)), 1'b0);
            cycle("bp_stall");
        end
        drive(1'b1, 0, 4'b1111, 1'b1); cycle("bp_drain");

        // Mode switch: RR 0,1 then explicit 0 twice, then RR resumes at 2.
        for (int n = 0; n < 2; n++) begin drive(1'b1, 0, 4'b1111, 1'b1); cycle("ms_rr"); end
        for (int n = 0; n < 2; n++) begin drive(1'b0, 0, 4'b1111, 1'b1); cycle("ms_expl"); end
        drive(1'b1, 0, 4'b1111, 1'b1); cycle("ms_back");

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) d[i] = $urandom;
            drive(1'($urandom), int'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
            cycle("rand");
        end

        // Mid-stream asynchronous reset while holding 0xDEADBEEF under stall.
        d[0] = 32'hDEADBEEF;
        drive(1'b0, 0, 4'b1111, 1'b1); cycle("pre_rst");
        if (m_valid && !out_ready) begin
            drive(1'b0, 0, 4'b1111, 1'b1); cycle("pre_rst2");
        end
        drive(1'b0, 0, 4'b1111, 1'b0); cycle("hold");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.out_valid", out_valid, 1'b0);
        check("arst.out_data",  out_data,  32'h0);
        check("arst.out_sel",   out_sel,   2'd0);
        check("arst.in_ready",  in_ready,  4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin drive(1'b1, 0, 4'b0000, 1'b1); cycle("idle"); end

        // 3-input instance: in-range select works, out-of-range never grants.
        sel3 = 2'd1;
        #1;
        check("n3.rdy_sel1", in_ready3, 3'b010);
        @(posedge clk); #1;
        check("n3.valid_sel1", out_valid3, 1'b1);
        check("n3.data_sel1",  out_data3,  32'h21);
        check("n3.sel_sel1",   out_sel3,   2'd1);
        @(negedge clk);
        sel3 = 2'd3;
        for (int n = 0; n < 4; n++) begin drive(1'b0, 0, 4'b0000, 1'b1); cycle("n3_oor"); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nway_reg.md
# mux_nway_reg

Parametrised, registered N-input, WIDTH-bit selector with valid/ready handshaking on every input and on the output. It generalises the 2:1 fixed-width datapath mux into a pipelined channel selector for the matrix-multiply datapath. It supports two modes: explicit select, and round-robin arbitration among valid inputs. It holds one output entry and sustains one transfer per cycle.

## Interface
- WIDTH, 32, data width of each channel
- NUM_IN, 4, number of input channels (2..16)
- SEL_W, 2, select/pointer width; must satisfy 2^SEL_W >= NUM_IN
- Clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-low; clears all state immediately
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  channel i presents data
- in_ready  output  NUM_IN  channel i transfers this cycle (combinational)
- mode  input  1  0 = explicit select via sel; 1 = round-robin
- sel  input  SEL_W  channel index used when mode = 0
- out_data  output  WIDTH  registered selected data
- out_sel  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  out_data holds an entry
- out_ready  input  1  downstream accepts the entry

## Operation
- load_en = !out_valid || out_ready. The output register accepts a new entry only when load_en is high.
- Explicit mode (mode = 0):
  - grant = sel, if sel < NUM_IN and in_valid[sel].
  - Otherwise there is no grant. This includes sel >= NUM_IN, which is never granted and never raises any in_ready.
- Round-robin mode (mode = 1):
  - grant = the first i with in_valid[i] set, scanning ptr, ptr+1, … modulo NUM_IN.
  - There is no grant if in_valid is all zero.
- in_ready[i] = load_en && grant exists && grant == i. At most one bit of in_ready is high in any cycle.
- A transfer occurs on channel i when in_valid[i] && in_ready[i]. On that edge:
  - out_data <= channel i data
  - out_sel <= i
  - out_valid <= 1
- If load_en is high and there is no grant: out_valid <= 0, and out_data/out_sel hold their previous values.
- If load_en is low (out_valid && !out_ready): out_data, out_sel and out_valid hold stable.
- ptr (SEL_W bits, internal):
  - Updates only on a transfer in round-robin mode, to (grant+1) mod NUM_IN. Wrap is to 0 when grant = NUM_IN-1.
  - Explicit-mode transfers do not move ptr.
- mode and sel are sampled combinationally each cycle. A mode switch affects the grant in the same cycle and never corrupts a held entry.

## Timing
- Reset asserted (at any time, including mid-transfer or while stalled):
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - in_ready is all 0 while Reset is low.
  - Any held entry is discarded.
- Latency: input transfer at edge k gives out_valid = 1 with that data after edge k.
- Throughput: one entry per cycle while out_ready = 1 and a grant exists.
- Simultaneous output drain and input load in the same cycle: the new entry replaces the old one; no bubble is inserted.
- Stall: while out_valid && !out_ready, all in_ready are 0 and the output is bit-stable.
- Upstream rule: a channel must hold in_data stable while in_valid is high and it is not accepted. Deasserting in_valid without a transfer is permitted.

## Test plan
- Reset and idle:
  - Stimulus: Reset low mid-stream, with out_valid = 1 and data 0xDEADBEEF held.
  - Required: out_valid, out_data, out_sel and in_ready all 0 immediately (asynchronously). After release with no inputs valid, out_valid stays 0.
- Explicit select:
  - Stimulus: mode = 0, sel = 2, all four channels valid with data 0x10..0x13, out_ready = 1.
  - Required: in_ready = 4'b0100; out_data = 0x12 and out_sel = 2 one cycle later, on every cycle. sel = 3 with in_valid[3] = 0 gives out_valid = 0 next cycle.
- Round-robin fairness:
  - Stimulus: mode = 1, all valid, out_ready = 1 for 8 cycles.
  - Required: out_sel sequence 0,1,2,3,0,1,2,3 (wrap verified).
  - Stimulus: only channels 1 and 3 valid.
  - Required: sequence 1,3,1,3.
- Backpressure:
  - Stimulus: transfer from channel 2, then out_ready = 0 for 3 cycles while inputs change.
  - Required: out_data/out_sel hold; in_ready = 0; ptr unchanged. On out_ready = 1 the next channel (3) transfers in the same cycle as the drain.
- Mode switch:
  - Stimulus: RR transfers on channels 0 and 1 (ptr = 2); switch to mode = 0 with sel = 0 for 2 transfers; switch back to mode = 1.
  - Required: explicit transfers come from channel 0; the first RR grant after returning is channel 2.
- Out-of-range select:
  - Stimulus: NUM_IN = 3, SEL_W = 2, mode = 0, sel = 3, all valid.
  - Required: in_ready = 0 and out_valid = 0 indefinitely.
